// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipelined_cla_adder_if                                         |
// | Purpose : Operand/result valid-ready bundle for pipelined_cla_adder.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipelined_cla_adder                                            |
// | Purpose : Slice-pipelined carry-look-ahead adder/subtractor, one slice   |
// |           per stage, valid/ready on both sides. Optional macro           |
// |           CLA_PIPE_OVF_EN builds the signed overflow flag.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pipelined_cla_adder_if.slave io
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int GROUPS = SLICE / 4;

  // Returns {carry_out, sum} of one slice built from chained 4-bit G/P groups.
  function automatic logic [SLICE:0] f_slice_add(
    input logic [SLICE-1:0] i_x,
    input logic [SLICE-1:0] i_y,
    input logic             i_c
  );
    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_c;
    logic             w_cg;
    logic             w_gg;
    logic             w_gp;
    w_g  = i_x & i_y;
    w_p  = i_x ^ i_y;
    w_c  = '0;
    w_cg = i_c;
    for (int j = 0; j < GROUPS; j++) begin
      w_c[4*j]   = w_cg;
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_cg);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+1] & w_p[4*j] & w_cg);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | ((&w_p[4*j +: 3]) & w_cg);
      w_gg = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
           | ((&w_p[4*j+2 +: 2]) & w_g[4*j+1])
           | ((&w_p[4*j+1 +: 3]) & w_g[4*j]);
      w_gp = &w_p[4*j +: 4];
      w_cg = w_gg | (w_gp & w_cg);
    end
    return {w_cg, w_p ^ w_c};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign w_adv       = !io.out_valid || io.out_ready;
  assign io.in_ready = w_adv;
  assign w_bx        = io.sub ? ~io.b : io.b;
  assign w_c0        = io.sub | io.cin;

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic             w_ci;
    logic             w_vin;
    logic [REM-1:0]   w_ua;
    logic [REM-1:0]   w_ub;
    logic [SLICE:0]   w_res;
    logic [DONE-1:0]  w_sum_nxt;

    logic             r_v;
    logic             r_c;
    logic [DONE-1:0]  r_s;
    logic [REM-1:0]   r_a;
    logic [REM-1:0]   r_b;

    if (k == 0) begin : g_first
      assign w_sa      = io.a[SLICE-1:0];
      assign w_sb      = w_bx[SLICE-1:0];
      assign w_ci      = w_c0;
      assign w_vin     = io.in_valid;
      assign w_ua      = io.a[WIDTH-1:SLICE];
      assign w_ub      = w_bx[WIDTH-1:SLICE];
      assign w_sum_nxt = w_res[SLICE-1:0];
    end else begin : g_mid
      assign w_sa      = g_stage[k-1].r_a[SLICE-1:0];
      assign w_sb      = g_stage[k-1].r_b[SLICE-1:0];
      assign w_ci      = g_stage[k-1].r_c;
      assign w_vin     = g_stage[k-1].r_v;
      assign w_ua      = g_stage[k-1].r_a[REM+SLICE-1:SLICE];
      assign w_ub      = g_stage[k-1].r_b[REM+SLICE-1:SLICE];
      assign w_sum_nxt = {w_res[SLICE-1:0], g_stage[k-1].r_s};
    end

    assign w_res = f_slice_add(w_sa, w_sb, w_ci);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
        r_a <= '0;
        r_b <= '0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_c <= w_res[SLICE];
          r_s <= w_sum_nxt;
          r_a <= w_ua;
          r_b <= w_ub;
        end
      end
    end
  end

  logic [SLICE-1:0] w_la;
  logic [SLICE-1:0] w_lb;
  logic             w_lc;
  logic             w_lv;
  logic [SLICE:0]   w_lres;
  logic [WIDTH-1:0] w_lsum;

  if (STAGES == 1) begin : g_last_from_port
    assign w_la   = io.a;
    assign w_lb   = w_bx;
    assign w_lc   = w_c0;
    assign w_lv   = io.in_valid;
    assign w_lsum = w_lres[SLICE-1:0];
  end else begin : g_last_from_pipe
    assign w_la   = g_stage[STAGES-2].r_a;
    assign w_lb   = g_stage[STAGES-2].r_b;
    assign w_lc   = g_stage[STAGES-2].r_c;
    assign w_lv   = g_stage[STAGES-2].r_v;
    assign w_lsum = {w_lres[SLICE-1:0], g_stage[STAGES-2].r_s};
  end

  assign w_lres = f_slice_add(w_la, w_lb, w_lc);

  logic             r_out_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Output data only loads on a real beat so it holds its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_adv) begin
      r_out_v <= w_lv;
      if (w_lv) begin
        r_sum  <= w_lsum;
        r_cout <= w_lres[SLICE];
      end
    end
  end

  assign io.out_valid = r_out_v;
  assign io.sum       = r_sum;
  assign io.cout      = r_cout;

`ifdef CLA_PIPE_OVF_EN
  logic w_cmsb;
  logic r_ovf;

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
  assign w_cmsb = w_lres[SLICE-1] ^ w_la[SLICE-1] ^ w_lb[SLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && w_lv) begin
      r_ovf <= w_cmsb ^ w_lres[SLICE];
    end
  end

  assign io.ovf = r_ovf;
`else
  assign io.ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipelined_cla_adder                                         |
// | Purpose : Scoreboard bench for pipelined_cla_adder (32/8 and 64/16).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipelined_cla_adder;

  localparam int W1  = 32;
  localparam int S1  = 8;
  localparam int ST1 = W1 / S1;
  localparam int W2  = 64;
  localparam int S2  = 16;
  localparam int ST2 = W2 / S2;
`ifdef CLA_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;
  int   cyc;
  bit   bp_mode;
  bit   lat_on;
  exp_t q1[$];
  exp_t q2[$];

  pipelined_cla_adder_if #(.WIDTH(W1)) if1 ();
  pipelined_cla_adder_if #(.WIDTH(W2)) if2 ();

  pipelined_cla_adder #(.WIDTH(W1), .SLICE(S1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if1)
  );

  pipelined_cla_adder #(.WIDTH(W2), .SLICE(S2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input bit ok, input string nm,
                                input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void pop_cmp(input int d, input logic [65:0] act, input int st);
    exp_t e;
    logic [65:0] req;
    if ((d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
      check(1'b0, "unexpected_out", act, '0);
      return;
    end
    if (d == 1) e = q1.pop_front();
    else        e = q2.pop_front();
    req = {e.o, e.c, e.s};
    check(act == req, (d == 1) ? "result32" : "result64", act, req);
    if (e.lat) check(cyc - e.acc == st, "latency", 66'(cyc - e.acc), 66'(st));
  endfunction

  // out_ready pattern for dut1: 1,0,0,1,0,0... in backpressure mode.
  initial begin : p_oready
    int pat;
    pat = 0;
    if1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        if1.out_ready = (pat == 0);
        pat = (pat + 1) % 3;
      end else begin
        if1.out_ready = 1'b1;
        pat = 0;
      end
    end
  end

  initial begin : p_mon
    bit          st1;
    logic [31:0] h1;
    st1 = 1'b0;
    h1  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st1 = 1'b0;
      end else begin
        if (st1) check(if1.out_valid && (if1.sum == h1), "stall_hold",
                       {33'd0, if1.out_valid, if1.sum}, {33'd0, 1'b1, h1});
        st1 = if1.out_valid && !if1.out_ready;
        if (st1) begin
          h1 = if1.sum;
          check(!if1.in_ready, "stall_in_ready", 66'(if1.in_ready), '0);
        end
        if (if1.out_valid && if1.out_ready)
          pop_cmp(1, {if1.ovf, if1.cout, 32'd0, if1.sum}, ST1);
        if (if2.out_valid && if2.out_ready)
          pop_cmp(2, {if2.ovf, if2.cout, if2.sum}, ST2);
      end
    end
  end

  task automatic send(input int d, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic sb,
                      input logic [63:0] es, input logic ec, input logic eo);
    exp_t e;
    bit   rdy;
    int   n;
    e.s = es; e.c = ec; e.o = eo & OVF_ON; e.acc = 0; e.lat = lat_on;
    if (d == 1) begin
      if1.a = a[31:0]; if1.b = b[31:0]; if1.cin = ci; if1.sub = sb; if1.in_valid = 1'b1;
    end else begin
      if2.a = a; if2.b = b; if2.cin = ci; if2.sub = sb; if2.in_valid = 1'b1;
    end
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (d == 1) ? if1.in_ready : if2.in_ready;
      if (rdy) begin
        e.acc = cyc;
        if (d == 1) q1.push_back(e);
        else        q2.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check(1'b0, "accept_timeout", 66'(n), 66'd200);
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(q1.size() == 0 && q2.size() == 0, "drain",
          66'(q1.size() + q2.size()), '0);
  endtask

  initial begin : p_main
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] bx;
    logic [64:0] full;
    logic        ci;
    logic        sb;
    logic        ov;
    rst_n = 1'b0;
    bp_mode = 1'b0;
    lat_on  = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.sub = 1'b0;
    if2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(!if1.out_valid, "rst_out_valid", 66'(if1.out_valid), '0);
    check(if1.sum == '0, "rst_sum", 66'(if1.sum), '0);
    check(!if1.cout, "rst_cout", 66'(if1.cout), '0);
    check(!if1.ovf, "rst_ovf", 66'(if1.ovf), '0);
    check(if1.in_ready, "rst_in_ready", 66'(if1.in_ready), 66'd1);
    check(!if2.out_valid, "rst_out_valid64", 66'(if2.out_valid), '0);
    @(posedge clk);
    #1;

    // Directed vectors, back to back, unstalled.
    send(1, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h0001_0000, 1'b0, 1'b0);
    send(1, 64'hFFFF_FFFF, 64'h0000_0000, 1'b1, 1'b0, 64'h0000_0000, 1'b1, 1'b0);
    send(1, 64'h0000_0005, 64'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
    send(1, 64'h0000_0007, 64'h0000_0005, 1'b0, 1'b1, 64'h0000_0002, 1'b1, 1'b0);
    send(1, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    send(1, 64'h8000_0000, 64'h0000_0001, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);
    send(1, 64'h00FF_00FF, 64'h0001_0001, 1'b0, 1'b0, 64'h0100_0100, 1'b0, 1'b0);
    send(1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, 64'hACF1_3568, 1'b0, 1'b0);
    drain();

    // Backpressure stream: i + i.
    bp_mode = 1'b1;
    lat_on  = 1'b0;
    for (int i = 0; i < 10; i++)
      send(1, 64'(i), 64'(i), 1'b0, 1'b0, 64'(2 * i), 1'b0, 1'b0);
    drain();
    bp_mode = 1'b0;
    lat_on  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with four beats in flight; none may ever emerge.
    for (int i = 0; i < 4; i++)
      send(1, 64'(i + 1), 64'd1, 1'b0, 1'b0, 64'(i + 2), 1'b0, 1'b0);
    check(if1.out_valid, "inflight_before_reset", 66'(if1.out_valid), 66'd1);
    rst_n = 1'b0;
    #1;
    check(!if1.out_valid, "reset_drops_valid", 66'(if1.out_valid), '0);
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(1, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h0000_0000, 1'b1, 1'b0);
    drain();

    // 64/16 instance against a plain arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      if (i % 5 == 0) a = sb ? b : ~b;
      bx   = sb ? ~b : b;
      full = {1'b0, a} + {1'b0, bx} + {64'd0, (sb | ci)};
      ov   = (a[63] == bx[63]) && (full[63] != a[63]);
      send(2, a, b, ci, sb, full[63:0], full[64], ov);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
